// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction-fetch unit.
package ifu_pkg;

  localparam int unsigned IFU_ADDR_W = 16;
  localparam logic [IFU_ADDR_W-1:0] IFU_RESET_PC = 16'h0000;
  localparam logic [31:0] INS_NOP = 32'h0000_0013;

  // One fetch-queue entry: the PC a word was fetched from and the word itself.
  typedef struct packed {
    logic [IFU_ADDR_W-1:0] pc;
    logic [31:0]           ins;
  } fetch_ent_t;

endpackage

// File: rtl/ifu_fifo.sv
// Fetch queue: small synchronous FIFO of fetch_ent_t with flush.
// Flush wins over push and pop. Head reads as all-zero while empty.
module ifu_fifo
  import ifu_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  fetch_ent_t                   wdata,
  output fetch_ent_t                   rdata,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  fetch_ent_t       mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [CNT_W-1:0] cnt_q;

  // Pointer and occupancy bookkeeping; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage is not reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= wdata;
  end

  // Head presentation, forced to zero while empty.
  always_comb begin
    rdata = '0;
    if (cnt_q != '0) rdata = mem_q[rd_ptr_q];
  end

  assign count = cnt_q;

endmodule

// File: rtl/ifu_fetch_ctl.sv
// Instruction-fetch front end: owns the fetch PC, drives the 1-cycle-latency
// instruction SRAM, queues returned words and hands {pc, ins} to decode.
// Optional build macro IFU_PERF_CNT_EN adds internal perf counters
// (perf_issue, perf_kill, perf_stall); ports and behaviour are unchanged.
// ADDR_W must equal ifu_pkg::IFU_ADDR_W, since queue entries use fetch_ent_t.
module ifu_fetch_ctl
  import ifu_pkg::*;
#(
  parameter int unsigned       ADDR_W   = IFU_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = IFU_RESET_PC,
  parameter int unsigned       QDEPTH   = 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              fetch_en,
  output logic [ADDR_W-1:0] ins_a,
  output logic              ins_e,
  input  logic [31:0]       ins,
  input  logic              redir_e,
  input  logic [ADDR_W-1:0] redir_pc,
  output logic              dec_vld,
  input  logic              dec_rdy,
  output logic [ADDR_W-1:0] dec_pc,
  output logic [31:0]       dec_ins
);

  localparam int unsigned       CNT_W    = $clog2(QDEPTH + 1);
  localparam logic [CNT_W:0]    QDEPTH_C = (CNT_W + 1)'(QDEPTH);
  localparam logic [ADDR_W-1:0] PC_INC   = ADDR_W'(4);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] req_pc_q, req_pc_d;
  logic [ADDR_W-1:0] ins_a_q;
  logic              inflight_q, inflight_d;
  logic              kill_q, kill_d;

  logic [ADDR_W-1:0] redir_addr;
  logic [ADDR_W-1:0] issue_addr;
  logic              issue;
  logic              push;
  logic              pop;
  logic              flush;
  logic [CNT_W:0]    occ;
  logic [CNT_W-1:0]  q_count;
  fetch_ent_t        wr_ent;
  fetch_ent_t        head;

  logic              unused_redir_lsb;
  assign unused_redir_lsb = ^redir_pc[1:0];

  // Issue/redirect decision, queue control and next-state for PC and in-flight tracking.
  always_comb begin
    redir_addr = {redir_pc[ADDR_W-1:2], 2'b00};
    push       = inflight_q & ~kill_q & ~redir_e;
    pop        = dec_vld & dec_rdy & ~redir_e;
    flush      = redir_e;
    // Occupancy next cycle if we issue now: held + landing - leaving must leave a slot.
    occ        = {1'b0, q_count} + {{CNT_W{1'b0}}, inflight_q} - {{CNT_W{1'b0}}, pop};
    issue      = 1'b0;
    issue_addr = pc_q;
    pc_d       = pc_q;
    if (redir_e) begin
      issue      = fetch_en;
      issue_addr = redir_addr;
      pc_d       = fetch_en ? redir_addr + PC_INC : redir_addr;
    end else if (fetch_en && (occ < QDEPTH_C)) begin
      issue = 1'b1;
      pc_d  = pc_q + PC_INC;
    end
    // Reset is asynchronous, so the request strobe must drop the moment it asserts.
    if (rstn) issue = 1'b0;
    inflight_d = issue;
    req_pc_d   = issue ? issue_addr : req_pc_q;
    // With single-cycle latency every pre-redirect response lands in the redirect
    // cycle itself and is dropped there, so a fresh request is never stale.
    kill_d     = 1'b0;
  end

  assign ins_e = issue;
  assign ins_a = issue ? issue_addr : ins_a_q;

  // Fetch state registers.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      pc_q       <= RESET_PC;
      req_pc_q   <= RESET_PC;
      ins_a_q    <= RESET_PC;
      inflight_q <= 1'b0;
      kill_q     <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      ins_a_q    <= ins_a;
      inflight_q <= inflight_d;
      kill_q     <= kill_d;
    end
  end

  assign wr_ent.pc  = req_pc_q;
  assign wr_ent.ins = ins;

  ifu_fifo #(
    .DEPTH (QDEPTH)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata (wr_ent),
    .rdata (head),
    .count (q_count)
  );

  assign dec_vld = (q_count != '0);
  assign dec_pc  = head.pc;
  assign dec_ins = head.ins;

`ifdef IFU_PERF_CNT_EN
  logic [31:0] perf_issue;
  logic [31:0] perf_kill;
  logic [31:0] perf_stall;

  // Saturating event counters for issue, discarded responses and stalled fetch cycles.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      perf_issue <= '0;
      perf_kill  <= '0;
      perf_stall <= '0;
    end else begin
      if (issue && (perf_issue != '1)) perf_issue <= perf_issue + 1'b1;
      if (inflight_q && (kill_q || redir_e) && (perf_kill != '1)) perf_kill <= perf_kill + 1'b1;
      if (fetch_en && !issue && (perf_stall != '1)) perf_stall <= perf_stall + 1'b1;
    end
  end
`else
  // Perf counters not built.
`endif

endmodule

// File: tb/tb_ifu_fetch_ctl.sv
// Directed bench for ifu_fetch_ctl with a 1-cycle-latency SRAM model.
module tb_ifu_fetch_ctl;

  logic        clk;
  logic        rstn;
  logic        fetch_en;
  logic [15:0] ins_a;
  logic        ins_e;
  logic [31:0] ins;
  logic        redir_e;
  logic [15:0] redir_pc;
  logic        dec_vld;
  logic        dec_rdy;
  logic [15:0] dec_pc;
  logic [31:0] dec_ins;

  int checks = 0;
  int errors = 0;
  int issues;

  ifu_fetch_ctl #(
    .ADDR_W   (16),
    .RESET_PC (16'h0000),
    .QDEPTH   (2)
  ) u_dut (
    .clk      (clk),
    .rstn     (rstn),
    .fetch_en (fetch_en),
    .ins_a    (ins_a),
    .ins_e    (ins_e),
    .ins      (ins),
    .redir_e  (redir_e),
    .redir_pc (redir_pc),
    .dec_vld  (dec_vld),
    .dec_rdy  (dec_rdy),
    .dec_pc   (dec_pc),
    .dec_ins  (dec_ins)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM contents are a pure function of the address.
  function automatic logic [31:0] word(input logic [15:0] a);
    return {~a, a};
  endfunction

  always @(posedge clk) begin
    if (ins_e) ins <= word(ins_a);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Apply one cycle of inputs at the falling edge, then let combinational outputs settle.
  task automatic tick(input logic rst, input logic fe, input logic rdy, input logic re,
                      input logic [15:0] rpc);
    @(negedge clk);
    rstn     = rst;
    fetch_en = fe;
    dec_rdy  = rdy;
    redir_e  = re;
    redir_pc = rpc;
    #1;
  endtask

  initial begin
    rstn     = 1'b1;
    fetch_en = 1'b0;
    dec_rdy  = 1'b0;
    redir_e  = 1'b0;
    redir_pc = '0;
    ins      = '0;

    // Reset state, with fetch requested to show reset overrides it.
    tick(1, 1, 1, 0, 16'h0);
    check_eq("rst_ins_e", ins_e, 0);
    check_eq("rst_ins_a", ins_a, 16'h0000);
    check_eq("rst_dec_vld", dec_vld, 0);
    check_eq("rst_dec_pc", dec_pc, 0);
    check_eq("rst_dec_ins", dec_ins, 0);

    // Streaming at one instruction per cycle.
    for (int k = 0; k < 8; k++) begin
      tick(0, 1, 1, 0, 16'h0);
      check_eq("strm_ins_e", ins_e, 1);
      check_eq("strm_ins_a", ins_a, 32'(4 * k));
      if (k < 2) begin
        check_eq("strm_vld_lat", dec_vld, 0);
      end else begin
        check_eq("strm_dec_vld", dec_vld, 1);
        check_eq("strm_dec_pc", dec_pc, 32'(4 * (k - 2)));
        check_eq("strm_dec_ins", dec_ins, word(16'(4 * (k - 2))));
      end
    end

    // Decode stalled: exactly QDEPTH issues, then hold.
    tick(1, 1, 0, 0, 16'h0);
    issues = 0;
    for (int k = 0; k < 5; k++) begin
      tick(0, 1, 0, 0, 16'h0);
      issues += int'(ins_e);
      if (k >= 2) check_eq("stall_ins_a_hold", ins_a, 16'h0004);
    end
    check_eq("stall_issues", issues, 2);
    check_eq("stall_dec_vld", dec_vld, 1);
    check_eq("stall_dec_pc", dec_pc, 16'h0000);
    check_eq("stall_count", u_dut.q_count, 2);
    for (int k = 0; k < 5; k++) begin
      tick(0, 1, 1, 0, 16'h0);
      check_eq("resume_ins_e", ins_e, 1);
      check_eq("resume_ins_a", ins_a, 32'(8 + 4 * k));
      check_eq("resume_dec_pc", dec_pc, 32'(4 * k));
      check_eq("resume_dec_ins", dec_ins, word(16'(4 * k)));
    end

    // Redirect with an entry queued and a response in flight.
    tick(0, 1, 1, 1, 16'h0102);
    check_eq("redir_ins_e", ins_e, 1);
    check_eq("redir_ins_a", ins_a, 16'h0100);
    tick(0, 1, 1, 0, 16'h0);
    check_eq("redir_flush_vld", dec_vld, 0);
    check_eq("redir_next_a", ins_a, 16'h0104);
    tick(0, 1, 1, 0, 16'h0);
    check_eq("redir_dec_vld", dec_vld, 1);
    check_eq("redir_dec_pc", dec_pc, 16'h0100);
    check_eq("redir_dec_ins", dec_ins, word(16'h0100));
    tick(0, 1, 1, 0, 16'h0);
    check_eq("redir_dec_pc2", dec_pc, 16'h0104);

    // Redirect while fetch is disabled, then enable.
    tick(0, 0, 1, 1, 16'h0040);
    check_eq("redir_off_ins_e", ins_e, 0);
    tick(0, 1, 1, 0, 16'h0);
    check_eq("redir_off_ins_e1", ins_e, 1);
    check_eq("redir_off_ins_a", ins_a, 16'h0040);
    check_eq("redir_off_vld", dec_vld, 0);
    tick(0, 1, 1, 0, 16'h0);
    check_eq("redir_off_ins_a2", ins_a, 16'h0044);
    tick(0, 1, 1, 0, 16'h0);
    check_eq("redir_off_dec_pc", dec_pc, 16'h0040);

    // PC wrap-around.
    tick(0, 1, 1, 1, 16'hFFFC);
    check_eq("wrap_ins_a0", ins_a, 16'hFFFC);
    tick(0, 1, 1, 0, 16'h0);
    check_eq("wrap_ins_a1", ins_a, 16'h0000);
    tick(0, 1, 1, 0, 16'h0);
    check_eq("wrap_dec_pc0", dec_pc, 16'hFFFC);
    check_eq("wrap_dec_ins0", dec_ins, word(16'hFFFC));
    tick(0, 1, 1, 0, 16'h0);
    check_eq("wrap_dec_pc1", dec_pc, 16'h0000);
    check_eq("wrap_dec_ins1", dec_ins, word(16'h0000));

    // Fill the queue, then reset mid-stream.
    tick(0, 1, 0, 0, 16'h0);
    check_eq("full_ins_e", ins_e, 0);
    tick(1, 1, 0, 0, 16'h0);
    check_eq("mrst_dec_vld", dec_vld, 0);
    check_eq("mrst_ins_e", ins_e, 0);
    check_eq("mrst_ins_a", ins_a, 16'h0000);
    tick(0, 1, 1, 0, 16'h0);
    check_eq("mrst_restart_e", ins_e, 1);
    check_eq("mrst_restart_a", ins_a, 16'h0000);
    check_eq("mrst_vld0", dec_vld, 0);
    tick(0, 1, 1, 0, 16'h0);
    check_eq("mrst_vld1", dec_vld, 0);
    check_eq("mrst_ins_a1", ins_a, 16'h0004);
    tick(0, 1, 1, 0, 16'h0);
    check_eq("mrst_dec_vld2", dec_vld, 1);
    check_eq("mrst_dec_pc", dec_pc, 16'h0000);
    check_eq("mrst_dec_ins", dec_ins, word(16'h0000));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
